demux_1x2_3bit_buf: RTL and testbench
=====================================

Name: demux_1x2_3bit_buf

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake; the inverse of the team's 2-to-1 3-bit select path.
- Takes one 3-bit input stream and steers each accepted word to output 0 or output 1.
- Steering follows the select input, or in alternate mode a round-robin pointer.
- Each output has a one-entry holding slot so a stalled consumer never corrupts the other path.

Parameters:
- WIDTH, 3, data width of input and both outputs.
- CNT_W, 8, width of per-output delivery counters (optional feature only).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  WIDTH  input data word.
- s  input  1  destination select: 0 = output 0, 1 = output 1 (used when alt_mode=0).
- alt_mode  input  1  1 = alternate destinations per accepted word, ignoring s.
- in_valid  input  1  x is valid this cycle.
- in_ready  output  1  block accepts x this cycle.
- m0  output  WIDTH  output 0 data.
- m0_valid  output  1  m0 holds a word.
- m0_ready  input  1  consumer 0 takes m0.
- m1  output  WIDTH  output 1 data.
- m1_valid  output  1  m1 holds a word.
- m1_ready  input  1  consumer 1 takes m1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: m0=m1=0, m0_valid=m1_valid=0, alt_ptr=0, counters=0.
- in_ready is combinational from slot state and mk_ready, with no dependence on in_valid.
- Reset mid-operation discards any buffered words; nothing is delivered after reset.
- Target select: tgt = alt_mode ? alt_ptr : s, evaluated each cycle.
- Accept: in_valid && in_ready.
- alt_ptr toggles on every accept while alt_mode=1.
- alt_ptr holds its value while alt_mode=0 and resumes from that value when alt_mode returns to 1.
- Slot FSM per output k has two states: EMPTY (mk_valid=0) and FULL (mk_valid=1).
  - EMPTY -> FULL on accept with tgt=k.
  - FULL -> EMPTY on mk_ready with no accept to k.
  - FULL -> FULL on mk_ready together with an accept to k: new word is loaded and mk_valid stays 1 (back-to-back, 1 word/cycle).
  - FULL with mk_ready=0: mk holds its value and stays stable.
- in_ready = !mk_valid[tgt] || mk_ready[tgt]. It depends only on the targeted slot; the other slot never blocks.
- Latency: an accepted word appears on mk in the next cycle. There is no combinational x->mk path.
- The unselected output's data and valid never change due to an accept.
- If s or alt_mode changes while in_valid=1 && in_ready=0, tgt is re-evaluated; the word goes wherever tgt points at the accepting edge.
- x is ignored when in_valid=0.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Adds outputs cnt0 and cnt1 [CNT_W-1:0].
  - cntk increments on each mk_valid && mk_ready.
  - Counters saturate at 2^CNT_W-1 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - DEMUX_W = 3 and DEMUX_CNT_W = 8 defaults.
  - Slot state encodings SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1.
  - DST0 = 1'b0, DST1 = 1'b1.
- One sub-module: demux_out_slot (one-entry register slot with load/drain/valid).
- demux_out_slot is instantiated twice; the top level holds the tgt/alt_ptr logic and in_ready.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1, x=3'b101 -> m0_valid=m1_valid=0, m0=m1=0, in_ready=1 after release.
- Select steering: alt_mode=0; send x=3'b011 with s=0, then 3'b110 with s=1, both readies=1 -> m0=3'b011 valid one cycle later, then m1=3'b110; cnt0=cnt1=1 with DEMUX_STATS_EN.
- Stall isolation: m0_ready=0, send 3'b001 to out0, then 3'b010 to out0 -> second word stalls with in_ready=0 and m0 stays 3'b001. Switch s=1 with x=3'b100 -> accepted immediately, m1=3'b100.
- Back-to-back drain: out0 full, m0_ready=1, accept 3'b111 to out0 in the same cycle -> m0_valid stays 1, m0=3'b111 next cycle.
- Alternate mode: alt_mode=1, send 3'b001, 3'b010, 3'b011, 3'b100 with both readies=1 -> m0 gets 001 and 011, m1 gets 010 and 100. Drop alt_mode after two words -> pointer holds at 0.
- Mid-op reset and saturation: reset while both slots are full -> both valid=0 next cycle. With CNT_W=2, deliver 5 words to out1 -> cnt1=3.

Source files
------------

// File: rtl/demux_1x2_3bit_buf_pkg.sv
// rtl/demux_1x2_3bit_buf_pkg.sv - shared constants and types for the 1-to-2 registered demux
// Holds the default widths, slot state encoding and destination codes.
// Optional counter feature macro: DEMUX_STATS_EN.
package demux_1x2_3bit_buf_pkg;

    localparam int DEMUX_W     = 3;
    localparam int DEMUX_CNT_W = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam logic DST0 = 1'b0;
    localparam logic DST1 = 1'b1;

endpackage

// File: rtl/demux_1x2_3bit_buf_if.sv
// rtl/demux_1x2_3bit_buf_if.sv - handshake bundle for the 1-to-2 registered demux
// Signals:
//   x, s, alt_mode, in_valid / in_ready : input stream and steering controls
//   m0, m0_valid / m0_ready             : output 0 stream
//   m1, m1_valid / m1_ready             : output 1 stream
//   cnt0, cnt1                          : delivery counters (DEMUX_STATS_EN only)
// Modports: master = producer/consumer side, slave = demux side.
interface demux_1x2_3bit_buf_if #(
    parameter int WIDTH = demux_1x2_3bit_buf_pkg::DEMUX_W
`ifdef DEMUX_STATS_EN
   ,parameter int CNT_W = demux_1x2_3bit_buf_pkg::DEMUX_CNT_W
`endif
);

    logic [WIDTH-1:0] x;
    logic             s;
    logic             alt_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] m0;
    logic             m0_valid;
    logic             m0_ready;
    logic [WIDTH-1:0] m1;
    logic             m1_valid;
    logic             m1_ready;
`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output x, s, alt_mode, in_valid, m0_ready, m1_ready,
        input  in_ready, m0, m0_valid, m1, m1_valid, cnt0, cnt1
    );

    modport slave (
        input  x, s, alt_mode, in_valid, m0_ready, m1_ready,
        output in_ready, m0, m0_valid, m1, m1_valid, cnt0, cnt1
    );
`else
    modport master (
        output x, s, alt_mode, in_valid, m0_ready, m1_ready,
        input  in_ready, m0, m0_valid, m1, m1_valid
    );

    modport slave (
        input  x, s, alt_mode, in_valid, m0_ready, m1_ready,
        output in_ready, m0, m0_valid, m1, m1_valid
    );
`endif

endinterface

// File: rtl/demux_1x2_3bit_buf_out_slot.sv
// rtl/demux_1x2_3bit_buf_out_slot.sv - one-entry output holding slot (module demux_out_slot)
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load_i, data_i : write a new word into the slot this cycle
//   ready_i        : downstream consumer takes the held word
//   data_o, valid_o: held word and its valid flag (both registered)
//   cnt_o          : saturating delivery count (DEMUX_STATS_EN only)
module demux_out_slot
    import demux_1x2_3bit_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_W
`ifdef DEMUX_STATS_EN
   ,parameter int CNT_W = DEMUX_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
`ifdef DEMUX_STATS_EN
   ,output logic [CNT_W-1:0] cnt_o
`endif
);

    slot_state_e      state_q;
    logic [WIDTH-1:0] data_q;

    // The top only raises load_i when the slot is empty or draining, so a
    // load in FULL always coincides with ready_i and replaces the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else if (state_q == SLOT_EMPTY) begin
            if (load_i) begin
                state_q <= SLOT_FULL;
                data_q  <= data_i;
            end
        end else begin
            if (load_i) begin
                data_q <= data_i;
            end else if (ready_i) begin
                state_q <= SLOT_EMPTY;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = (state_q == SLOT_FULL);

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (valid_o && ready_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_1x2_3bit_buf.sv
// rtl/demux_1x2_3bit_buf.sv - registered 1-to-2 demux with per-output holding slots
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : demux_1x2_3bit_buf_if.slave (input stream, two output streams,
//           delivery counters when DEMUX_STATS_EN is defined)
// Steering uses s, or a round-robin pointer when alt_mode=1.
module demux_1x2_3bit_buf
    import demux_1x2_3bit_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_W
`ifdef DEMUX_STATS_EN
   ,parameter int CNT_W = DEMUX_CNT_W
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    demux_1x2_3bit_buf_if.slave     bus
);

    logic alt_ptr_q;
    logic alt_ptr_d;
    logic tgt;
    logic accept;
    logic load0;
    logic load1;

    assign tgt = bus.alt_mode ? alt_ptr_q : bus.s;

    // Only the targeted slot gates the input; the other slot never blocks.
    assign bus.in_ready = (tgt == DST0) ? (!bus.m0_valid || bus.m0_ready)
                                        : (!bus.m1_valid || bus.m1_ready);

    assign accept = bus.in_valid && bus.in_ready;
    assign load0  = accept && (tgt == DST0);
    assign load1  = accept && (tgt == DST1);

    // Pointer advances only on accepts made in alternate mode, so it resumes
    // where it left off when alt_mode is re-enabled.
    assign alt_ptr_d = (accept && bus.alt_mode) ? ~alt_ptr_q : alt_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            alt_ptr_q <= DST0;
        end else begin
            alt_ptr_q <= alt_ptr_d;
        end
    end

    demux_out_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_STATS_EN
       ,.CNT_W (CNT_W)
`endif
    ) u_slot0 (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load0),
        .data_i  (bus.x),
        .ready_i (bus.m0_ready),
        .data_o  (bus.m0),
        .valid_o (bus.m0_valid)
`ifdef DEMUX_STATS_EN
       ,.cnt_o   (bus.cnt0)
`endif
    );

    demux_out_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_STATS_EN
       ,.CNT_W (CNT_W)
`endif
    ) u_slot1 (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load1),
        .data_i  (bus.x),
        .ready_i (bus.m1_ready),
        .data_o  (bus.m1),
        .valid_o (bus.m1_valid)
`ifdef DEMUX_STATS_EN
       ,.cnt_o   (bus.cnt1)
`endif
    );

endmodule

// File: tb/tb_demux_1x2_3bit_buf.sv
// tb/tb_demux_1x2_3bit_buf.sv - directed self-checking bench for demux_1x2_3bit_buf
module tb_demux_1x2_3bit_buf;

    logic clk;
    logic reset;
    int   total;
    int   bad;

`ifdef DEMUX_STATS_EN
    demux_1x2_3bit_buf_if #(.WIDTH(3), .CNT_W(2)) bus ();
    demux_1x2_3bit_buf #(.WIDTH(3), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    demux_1x2_3bit_buf_if #(.WIDTH(3)) bus ();
    demux_1x2_3bit_buf #(.WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset held two cycles with a valid word present
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.x        = 3'b101;
        bus.s        = 1'b0;
        bus.alt_mode = 1'b0;
        bus.m0_ready = 1'b1;
        bus.m1_ready = 1'b1;
        step();
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_m0_valid", {7'd0, bus.m0_valid}, 8'd0);
        chk("rst_m1_valid", {7'd0, bus.m1_valid}, 8'd0);
        chk("rst_m0", {5'd0, bus.m0}, 8'd0);
        chk("rst_m1", {5'd0, bus.m1}, 8'd0);
        chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
`ifdef DEMUX_STATS_EN
        chk("rst_cnt0", {6'd0, bus.cnt0}, 8'd0);
        chk("rst_cnt1", {6'd0, bus.cnt1}, 8'd0);
`endif

        // Select steering
        bus.s = 1'b0; bus.x = 3'b011; bus.in_valid = 1'b1;
        #1;
        chk("sel_in_ready0", {7'd0, bus.in_ready}, 8'd1);
        step();
        chk("sel_m0", {5'd0, bus.m0}, 8'h03);
        chk("sel_m0_valid", {7'd0, bus.m0_valid}, 8'd1);
        chk("sel_m1_valid_a", {7'd0, bus.m1_valid}, 8'd0);
        bus.s = 1'b1; bus.x = 3'b110;
        step();
        chk("sel_m1", {5'd0, bus.m1}, 8'h06);
        chk("sel_m1_valid", {7'd0, bus.m1_valid}, 8'd1);
        chk("sel_m0_drained", {7'd0, bus.m0_valid}, 8'd0);
        bus.in_valid = 1'b0;
        step();
        chk("sel_m1_drained", {7'd0, bus.m1_valid}, 8'd0);
`ifdef DEMUX_STATS_EN
        chk("sel_cnt0", {6'd0, bus.cnt0}, 8'd1);
        chk("sel_cnt1", {6'd0, bus.cnt1}, 8'd1);
`endif

        // Stall isolation
        bus.m0_ready = 1'b0; bus.s = 1'b0; bus.x = 3'b001; bus.in_valid = 1'b1;
        step();
        chk("stall_m0_first", {5'd0, bus.m0}, 8'h01);
        bus.x = 3'b010;
        #1;
        chk("stall_in_ready", {7'd0, bus.in_ready}, 8'd0);
        step();
        chk("stall_m0_hold", {5'd0, bus.m0}, 8'h01);
        chk("stall_m0_valid", {7'd0, bus.m0_valid}, 8'd1);
        bus.s = 1'b1; bus.x = 3'b100;
        #1;
        chk("stall_other_ready", {7'd0, bus.in_ready}, 8'd1);
        step();
        chk("stall_m1", {5'd0, bus.m1}, 8'h04);
        chk("stall_m1_valid", {7'd0, bus.m1_valid}, 8'd1);
        chk("stall_m0_unchanged", {5'd0, bus.m0}, 8'h01);

        // Back-to-back drain and reload on output 0
        bus.m0_ready = 1'b1; bus.s = 1'b0; bus.x = 3'b111;
        #1;
        chk("b2b_in_ready", {7'd0, bus.in_ready}, 8'd1);
        step();
        chk("b2b_m0_valid", {7'd0, bus.m0_valid}, 8'd1);
        chk("b2b_m0", {5'd0, bus.m0}, 8'h07);
        chk("b2b_m1_drained", {7'd0, bus.m1_valid}, 8'd0);
        bus.in_valid = 1'b0;
        step();
        chk("b2b_m0_drained", {7'd0, bus.m0_valid}, 8'd0);

        // Alternate mode, pointer starts at output 0
        bus.alt_mode = 1'b1; bus.s = 1'b1; bus.in_valid = 1'b1; bus.x = 3'b001;
        step();
        chk("alt_w0_m0", {5'd0, bus.m0}, 8'h01);
        chk("alt_w0_m1_valid", {7'd0, bus.m1_valid}, 8'd0);
        bus.x = 3'b010;
        step();
        chk("alt_w1_m1", {5'd0, bus.m1}, 8'h02);
        chk("alt_w1_m0_valid", {7'd0, bus.m0_valid}, 8'd0);
        bus.x = 3'b011;
        step();
        chk("alt_w2_m0", {5'd0, bus.m0}, 8'h03);
        chk("alt_w2_m0_valid", {7'd0, bus.m0_valid}, 8'd1);
        bus.x = 3'b100;
        step();
        chk("alt_w3_m1", {5'd0, bus.m1}, 8'h04);
        chk("alt_w3_m1_valid", {7'd0, bus.m1_valid}, 8'd1);
        // Leave alternate mode: s steers, pointer stays at 0
        bus.alt_mode = 1'b0; bus.s = 1'b1; bus.x = 3'b101;
        step();
        chk("alt_off_m1", {5'd0, bus.m1}, 8'h05);
        chk("alt_off_m0_valid", {7'd0, bus.m0_valid}, 8'd0);
        bus.alt_mode = 1'b1; bus.x = 3'b110;
        step();
        chk("alt_resume_m0", {5'd0, bus.m0}, 8'h06);
        chk("alt_resume_m0_valid", {7'd0, bus.m0_valid}, 8'd1);
        chk("alt_resume_m1_valid", {7'd0, bus.m1_valid}, 8'd0);

        // x ignored without in_valid
        bus.in_valid = 1'b0; bus.x = 3'b111;
        step();
        chk("idle_m0_valid", {7'd0, bus.m0_valid}, 8'd0);
        chk("idle_m1_valid", {7'd0, bus.m1_valid}, 8'd0);
        chk("idle_m0_data", {5'd0, bus.m0}, 8'h06);

        // Mid-operation reset with both slots full
        bus.alt_mode = 1'b0; bus.m0_ready = 1'b0; bus.m1_ready = 1'b0;
        bus.in_valid = 1'b1; bus.s = 1'b0; bus.x = 3'b010;
        step();
        bus.s = 1'b1; bus.x = 3'b011;
        step();
        chk("mid_full0", {7'd0, bus.m0_valid}, 8'd1);
        chk("mid_full1", {7'd0, bus.m1_valid}, 8'd1);
        reset = 1'b1; bus.in_valid = 1'b0;
        step();
        chk("mid_rst_m0_valid", {7'd0, bus.m0_valid}, 8'd0);
        chk("mid_rst_m1_valid", {7'd0, bus.m1_valid}, 8'd0);
        chk("mid_rst_m0", {5'd0, bus.m0}, 8'd0);
        reset = 1'b0; bus.m0_ready = 1'b1; bus.m1_ready = 1'b1;
        step();
        chk("post_rst_m0_valid", {7'd0, bus.m0_valid}, 8'd0);
        chk("post_rst_m1_valid", {7'd0, bus.m1_valid}, 8'd0);

        // Five words to output 1: counter saturates at 3 with CNT_W=2
        bus.s = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.x = 3'(i + 1);
            step();
        end
        chk("sat_m1_last", {5'd0, bus.m1}, 8'h05);
        bus.in_valid = 1'b0;
        step();
        chk("sat_m1_drained", {7'd0, bus.m1_valid}, 8'd0);
`ifdef DEMUX_STATS_EN
        chk("sat_cnt1", {6'd0, bus.cnt1}, 8'd3);
        chk("sat_cnt0", {6'd0, bus.cnt0}, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
